// File: rtl/lfsr_checker.sv
// Self-synchronising serial checker for the Galois LFSR pattern generator.
// Optional feature macro: LFSR_CHK_BITCNT_EN adds the bit_count output.
module lfsr_checker #(
    parameter int             N           = 20,
    parameter logic [N-1:0]   TAP_MASK    = 20'h80004,
    parameter int             LOCK_CNT    = 8,
    parameter int             LOSS_THRESH = 4,
    parameter int             ERRW        = 16
) (
    input  logic            clk,
    input  logic            r,
    input  logic            clear,
    input  logic            in_valid,
    input  logic            in_bit,
    output logic            locked,
    output logic            err,
    output logic [ERRW-1:0] err_count
`ifdef LFSR_CHK_BITCNT_EN
    ,
    output logic [31:0]     bit_count
`endif
);

    localparam int FW = $clog2(N + 1);
    localparam int OW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      h_q, h_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [OW-1:0]     ok_q, ok_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic [ERRW-1:0]   cnt_d;
    logic              err_d;
    logic              pred;
    logic              match;

    // Predict the next bit from the received history (h[0] newest).
    always_comb begin
        pred = h_q[N-1];
        for (int i = 1; i < N; i++) begin
            if (TAP_MASK[i]) begin
                pred = pred ^ h_q[N-1-i];
            end
        end
    end

    assign match  = (in_bit == pred);
    assign locked = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        fill_d  = fill_q;
        ok_d    = ok_q;
        miss_d  = miss_q;
        cnt_d   = err_count;
        err_d   = 1'b0;
        if (clear) begin
            state_d = HUNT;
            h_d     = '0;
            fill_d  = '0;
            ok_d    = '0;
            miss_d  = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            h_d = {h_q[N-2:0], in_bit};
            unique case (state_q)
                HUNT: begin
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FW'(N - 1)) begin
                        state_d = VERIFY;
                        ok_d    = '0;
                    end
                end
                VERIFY: begin
                    if (!match) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (h_q != '0) begin
                        // An all-zero history trivially matches; it must not count.
                        ok_d = ok_q + OW'(1);
                        if (ok_q == OW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + MW'(1);
                        if (err_count != '1) begin
                            cnt_d = err_count + ERRW'(1);
                        end
                        if (miss_q == MW'(LOSS_THRESH - 1)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q   <= HUNT;
            h_q       <= '0;
            fill_q    <= '0;
            ok_q      <= '0;
            miss_q    <= '0;
            err_count <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            ok_q      <= ok_d;
            miss_q    <= miss_d;
            err_count <= cnt_d;
            err       <= err_d;
        end
    end

`ifdef LFSR_CHK_BITCNT_EN
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            bit_count <= '0;
        end else if (clear) begin
            bit_count <= '0;
        end else if (in_valid && state_q == LOCKED && bit_count != '1) begin
            bit_count <= bit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: driver queues expectations per valid bit,
// a monitor compares the registered outputs one cycle after each sampled bit.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        r = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
`ifdef LFSR_CHK_BITCNT_EN
    logic [31:0] bit_count;
`endif

    lfsr_checker dut (
        .clk       (clk),
        .r         (r),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
`ifdef LFSR_CHK_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    lk;
        int    er;
        int    ec;
        string nm;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] g = 20'h1;
    logic [19:0] rx = '0;

    // Reference stream: o[t] = o[t-1] ^ o[t-18] ^ o[t-20].
    function automatic logic gen_bit();
        logic b;
        b = g[19] ^ g[17] ^ g[0];
        g = {g[18:0], b};
        return b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    always @(posedge clk) begin
        if (in_valid && !clear && !r) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got 0 entries expected 1");
            end else begin
                e = q.pop_front();
                if (e.lk >= 0) chk({e.nm, "_locked"}, int'(locked), e.lk);
                if (e.er >= 0) chk({e.nm, "_err"}, int'(err), e.er);
                if (e.ec >= 0) chk({e.nm, "_err_count"}, int'(err_count), e.ec);
            end
        end
    end

    task automatic send(input logic b, input int lk, input int er,
                        input int ec, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        rx       = {rx[18:0], b};
        q.push_back('{lk, er, ec, nm});
    endtask

    task automatic run(input int n, input int lk, input int er,
                       input int ec, input string nm);
        for (int i = 0; i < n; i++) begin
            send(gen_bit(), lk, er, ec, nm);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        idle(1);
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input string nm);
        drain();
        @(negedge clk);
        r  = 1'b1;
        rx = '0;
        @(negedge clk);
        r = 1'b0;
        chk({nm, "_rst_locked"}, int'(locked), 0);
        chk({nm, "_rst_err"}, int'(err), 0);
        chk({nm, "_rst_err_count"}, int'(err_count), 0);
    endtask

    // One flipped bit re-appears at taps 1, 18 and 20 as it ages out.
    task automatic single_flip(input int base, input string nm);
        send(~gen_bit(), 1, 1, base + 1, {nm, "_off0"});
        send(gen_bit(), 1, 1, base + 2, {nm, "_off1"});
        run(16, 1, 0, base + 2, {nm, "_clean_a"});
        send(gen_bit(), 1, 1, base + 3, {nm, "_off18"});
        send(gen_bit(), 1, 0, base + 3, {nm, "_off19"});
        send(gen_bit(), 1, 1, base + 4, {nm, "_off20"});
        run(10, 1, 0, base + 4, {nm, "_clean_b"});
    endtask

    initial begin
        // 1: lock exactly after N+LOCK_CNT bits, clean 1000-bit run
        do_reset("t1");
        run(27, 0, 0, 0, "t1_hunt");
        run(1, 1, 0, 0, "t1_lock");
        run(972, 1, 0, 0, "t1_run");

        // 2: single inverted bit while locked
        single_flip(0, "t2");

        // 3: four bits opposite to the received-history prediction
        for (int i = 0; i < 4; i++) begin
            send(~(rx[19] ^ rx[17] ^ rx[0]), (i == 3) ? 0 : 1, 1, 5 + i, "t3_anti");
        end
        run(27, 0, 0, 8, "t3_rehunt");
        run(1, 1, 0, 8, "t3_relock");

        // 4: all-zero stream never locks
        do_reset("t4");
        for (int i = 0; i < 200; i++) begin
            send(1'b0, 0, 0, 0, "t4_zero");
        end

        // 5: asynchronous reset while locked with a live error pulse
        do_reset("t5");
        run(27, 0, 0, 0, "t5_hunt");
        run(1, 1, 0, 0, "t5_lock");
        send(~gen_bit(), 1, 1, 1, "t5_flip");
        @(negedge clk);
        in_valid = 1'b0;
        #2 r = 1'b1;
        #1;
        chk("t5_async_locked", int'(locked), 0);
        chk("t5_async_err", int'(err), 0);
        chk("t5_async_err_count", int'(err_count), 0);
        @(negedge clk);
        r = 1'b0;
        run(27, 0, 0, 0, "t5_rehunt");
        run(1, 1, 0, 0, "t5_relock");

        // 6: clear together with a valid bit at err_count=5
        single_flip(0, "t6a");
        send(~gen_bit(), 1, 1, 5, "t6_flip5");
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t6_clear_err_count", int'(err_count), 0);
        chk("t6_clear_locked", int'(locked), 0);
        chk("t6_clear_err", int'(err), 0);
        run(27, 0, 0, 0, "t6_hunt");
        run(1, 1, 0, 0, "t6_lock");
        for (int i = 0; i < 12; i++) begin
            send(gen_bit(), 1, 0, 0, "t6_gap");
            idle(3);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
